// File: rtl/inv_bist_pkg.sv
// Shared types and constants for the inverter built-in self-test controller.
package inv_bist_pkg;
    localparam int INV_W = 4;

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_e;
endpackage

// File: rtl/bist_pattern_gen.sv
// Sweep code counter: clear to zero, step by one, flag the all-ones code.
module bist_pattern_gen #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] pat_o,
    output logic             last_o
);
    logic [WIDTH-1:0] pat_q, pat_d;

    always_comb begin
        pat_d = pat_q;
        if (clr_i)      pat_d = '0;
        else if (inc_i) pat_d = pat_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pat_q <= '0;
        else        pat_q <= pat_d;
    end

    assign pat_o  = pat_q;
    assign last_o = &pat_q;
endmodule

// File: rtl/inv_bist.sv
// BIST controller: sweeps every code into an inverter, checks for bitwise NOT,
// and reports pass, error count and first failing code. All outputs registered.
module inv_bist
    import inv_bist_pkg::*;
#(
    parameter int WIDTH  = INV_W,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    input  logic [WIDTH-1:0] dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic [WIDTH-1:0] first_fail
);
    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dut_a_q, dut_a_d, ff_q, ff_d;
    logic [WIDTH:0]   err_q, err_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic             pat_clr, pat_inc, pat_last, settle_end, mismatch;
    logic [WIDTH-1:0] pattern;

    bist_pattern_gen #(.WIDTH(WIDTH)) u_pat (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (pat_clr),
        .inc_i  (pat_inc),
        .pat_o  (pattern),
        .last_o (pat_last)
    );

    assign settle_end = (cnt_q == CW'(SETTLE - 1));
    assign mismatch   = (dut_y != ~pattern);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dut_a_q <= '0;
            ff_q    <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dut_a_q <= dut_a_d;
            ff_q    <= ff_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = APPLY;
            APPLY:      if (settle_end) state_d = CHECK;
            CHECK:      state_d = pat_last ? DONE : APPLY;
            default:    state_d = IDLE;
        endcase
    end

    // Output registers are loaded from the next state so they line up with it.
    always_comb begin
        cnt_d   = cnt_q;
        dut_a_d = dut_a_q;
        ff_d    = ff_q;
        err_d   = err_q;
        pat_clr = 1'b0;
        pat_inc = 1'b0;
        unique case (state_q)
            IDLE, DONE: if (start) begin
                pat_clr = 1'b1;
                dut_a_d = '0;
                err_d   = '0;
                ff_d    = '0;
                cnt_d   = '0;
            end
            APPLY: cnt_d = cnt_q + 1'b1;
            CHECK: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) ff_d = pattern;
                end
                if (!pat_last) begin
                    pat_inc = 1'b1;
                    dut_a_d = pattern + 1'b1;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
        busy_d = (state_d == APPLY) || (state_d == CHECK);
        done_d = (state_d == DONE);
        pass_d = (state_d == DONE) && (err_d == '0);
    end

    assign dut_a      = dut_a_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;
endmodule

// File: tb/tb_inv_bist.sv
// Scoreboard bench for inv_bist: two instances (SETTLE=1 with selectable inverter faults, SETTLE=3 golden).
module tb_inv_bist;
    typedef struct {
        int err;
        int ff;
        int pass;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    logic [3:0] dut_a0, dut_y0, ff0, dut_a1, dut_y1, ff1;
    logic [4:0] err0, err1;
    logic busy0, done0, pass0, busy1, done1, pass1;
    logic done0_p = 1'b0, done1_p = 1'b0;
    int   mode = 0;
    int   cyc = 0;
    int   ts0 = 0, ts1 = 0;
    bit   trk0 = 0, trk1 = 0;
    int   n_chk = 0, n_err = 0;
    exp_t q0[$], q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Inverter models: 0 golden, 1 bit0 stuck-0, 2 no inversion, 3 bit3 stuck-1
    always_comb begin
        case (mode)
            1:       dut_y0 = ~dut_a0 & 4'b1110;
            2:       dut_y0 = dut_a0;
            3:       dut_y0 = ~dut_a0 | 4'b1000;
            default: dut_y0 = ~dut_a0;
        endcase
    end
    assign dut_y1 = ~dut_a1;

    inv_bist #(.WIDTH(4), .SETTLE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .dut_a(dut_a0), .dut_y(dut_y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail(ff0));
    inv_bist #(.WIDTH(4), .SETTLE(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .dut_a(dut_a1), .dut_y(dut_y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1));

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitors: check the stepping code while busy, and pop/compare on done rising.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && trk0 && busy0) chk("u0_dut_a", dut_a0, (cyc - ts0) / 2);
        if (done0 && !done0_p) begin
            if (q0.size() == 0) chk("u0_unexpected_done", 1, 0);
            else begin
                e = q0.pop_front();
                chk("u0_err_count", err0, e.err);
                chk("u0_first_fail", ff0, e.ff);
                chk("u0_pass", pass0, e.pass);
                chk("u0_latency", cyc - ts0, e.lat);
                chk("u0_busy_done", busy0, 0);
                chk("u0_last_code", dut_a0, 15);
            end
        end
        done0_p <= done0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && trk1 && busy1) chk("u1_dut_a", dut_a1, (cyc - ts1) / 4);
        if (done1 && !done1_p) begin
            if (q1.size() == 0) chk("u1_unexpected_done", 1, 0);
            else begin
                e = q1.pop_front();
                chk("u1_err_count", err1, e.err);
                chk("u1_first_fail", ff1, e.ff);
                chk("u1_pass", pass1, e.pass);
                chk("u1_latency", cyc - ts1, e.lat);
            end
        end
        done1_p <= done1;
    end

    task automatic chk_zero0(input string tag);
        chk({tag, "_dut_a"}, dut_a0, 0);
        chk({tag, "_busy"}, busy0, 0);
        chk({tag, "_done"}, done0, 0);
        chk({tag, "_pass"}, pass0, 0);
        chk({tag, "_err"}, err0, 0);
        chk({tag, "_ff"}, ff0, 0);
    endtask

    // Issue start to u0 for one cycle and queue its expected result.
    task automatic go0(input int err, input int ff, input int ps);
        exp_t e;
        e = '{err: err, ff: ff, pass: ps, lat: 32};
        @(negedge clk);
        q0.push_back(e);
        ts0 = cyc + 1;
        trk0 = 1;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("u0_start_done_low", done0, 0);
        chk("u0_start_err_clr", err0, 0);
        chk("u0_start_busy", busy0, 1);
    endtask

    task automatic wait_empty0();
        int i;
        for (i = 0; i < 200 && q0.size() != 0; i++) @(negedge clk);
        if (q0.size() != 0) begin
            chk("u0_done_timeout", 0, 1);
            q0.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_code0(input int code);
        int i;
        for (i = 0; i < 100 && dut_a0 != 4'(code); i++) @(negedge clk);
        if (dut_a0 != 4'(code)) chk("u0_code_timeout", dut_a0, code);
    endtask

    initial begin
        int i;
        exp_t e;
        repeat (2) @(negedge clk);
        chk_zero0("rst0");
        chk("rst1_busy", busy1, 0);
        chk("rst1_done", done1, 0);
        rst_n = 1'b1;

        mode = 0; go0(0, 0, 1); wait_empty0();      // golden
        mode = 1; go0(8, 0, 0); wait_empty0();      // bit0 stuck at 0
        mode = 2; go0(16, 0, 0); wait_empty0();     // no inversion: full count
        mode = 3; go0(8, 8, 0); wait_empty0();      // bit3 stuck at 1

        // start while busy is ignored
        mode = 0; go0(0, 0, 1);
        wait_code0(5);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_empty0();

        // async reset mid-sweep
        go0(0, 0, 0);
        void'(q0.pop_back());
        wait_code0(9);
        #2;
        trk0 = 0;
        rst_n = 1'b0;
        #1;
        chk_zero0("arst");
        repeat (2) @(negedge clk);
        chk_zero0("arst_hold");
        rst_n = 1'b1;
        go0(0, 0, 1); wait_empty0();

        // SETTLE=3 golden sweep
        e = '{err: 0, ff: 0, pass: 1, lat: 64};
        @(negedge clk);
        q1.push_back(e);
        ts1 = cyc + 1;
        trk1 = 1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (i = 0; i < 200 && q1.size() != 0; i++) @(negedge clk);
        if (q1.size() != 0) chk("u1_done_timeout", 0, 1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/inv_bist.md
Name: inv_bist

Overview:
Hardware built-in self-test controller that drives the stimulus side of the team's N-bit inverter and checks its response. It sweeps every input code from 0 to 2^WIDTH-1 into the inverter, samples the inverter output after a settle window, and compares it against the bitwise NOT of the applied code. It reports busy, done, pass, an error count and the first failing code. It sits beside the inverter instance, connecting to its input port and its output port.

Parameters:
- WIDTH, default 4: data width of the inverter under test.
- SETTLE, default 1: number of cycles the code is held before sampling; legal range >= 1.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: starts a sweep; sampled only in IDLE or DONE.
- dut_a, output, WIDTH: registered stimulus to the inverter input.
- dut_y, input, WIDTH: inverter output, sampled in CHECK.
- busy, output, 1: high in APPLY and CHECK.
- done, output, 1: high in DONE; held until the next start or reset.
- pass, output, 1: in DONE, equals (err_count == 0); 0 in all other states.
- err_count, output, WIDTH+1: number of mismatching codes in the current or last sweep.
- first_fail, output, WIDTH: code of the first mismatch; valid only when err_count != 0.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; dut_a = 0, busy = 0, done = 0, pass = 0, err_count = 0, first_fail = 0, internal pattern = 0, settle counter = 0. Reset asserted mid-sweep aborts immediately; no partial result is retained.
- States and transitions:
  - IDLE: start = 1 -> APPLY. On that edge, pattern = 0, dut_a = 0, err_count = 0, first_fail = 0, settle counter = 0.
  - APPLY: dut_a = pattern (held). The settle counter increments each cycle. After SETTLE cycles in APPLY -> CHECK.
  - CHECK: one cycle. dut_y is compared against ~pattern (WIDTH bits).
    - On mismatch: err_count += 1. If err_count was 0, first_fail = pattern.
    - If pattern == 2^WIDTH-1 -> DONE. Otherwise pattern += 1, dut_a updates to the new pattern on the same edge, counter cleared -> APPLY.
  - DONE: done = 1, busy = 0, pass = (err_count == 0), dut_a holds the last code. start = 1 -> restart exactly as from IDLE; done and pass drop on that edge.
- start is ignored while busy. It is level-sampled, so holding start high in DONE re-runs continuously.
- Timing: each code occupies SETTLE+1 cycles. If start is sampled at edge T, dut_a = 0 from T, and done rises at edge T + 2^WIDTH*(SETTLE+1). For WIDTH=4, SETTLE=1, done rises at T+32.
- Arithmetic: err_count is WIDTH+1 bits, so its maximum value 2^WIDTH cannot overflow. The pattern counter is WIDTH bits, and the sweep terminates at all-ones, so it never wraps.
- All outputs are registered. No combinational path exists from dut_y or start to any output.

Decomposition:
- Package inv_bist_pkg:
  - State enum: IDLE, APPLY, CHECK, DONE.
  - Default width constant: INV_W = 4.
- One natural sub-module, bist_pattern_gen: the WIDTH-bit pattern counter with clear, increment and last-code flag.
- The inverter itself is instantiated only in the bench or top level, never inside inv_bist.

Test Plan:
- Golden inverter connected, WIDTH=4, SETTLE=1, start pulsed at T -> dut_a steps 0..15, each code held 2 cycles; done at T+32; pass = 1; err_count = 0.
- dut_y bit0 stuck at 0 -> err_count = 8, first_fail = 4'b0000, pass = 0.
- dut_y = dut_a (no inversion) -> err_count = 16 (5'b10000), first_fail = 0, pass = 0, no overflow.
- start pulsed again during APPLY at pattern 5 -> ignored; sweep completes normally. Then start in DONE -> err_count clears, done drops, and a new sweep starts with dut_a = 0.
- rst_n low while pattern = 9 -> all outputs return to reset values immediately and asynchronously; the next start runs a full clean sweep.
- SETTLE=3 with the golden inverter -> each code held 4 cycles; done at T+64; pass = 1.
